// File: rtl/vote_tally.sv
// rtl/vote_tally.sv - ballot packet checker and per-candidate tally with saturating counters
// One packet moves through IDLE -> CHECK -> RESULT. A packet that arrives while one is in flight is dropped.
module vote_tally #(
  parameter logic [7:0]  BOOTH_ID = 8'h01,
  parameter int unsigned NUM_CAND = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:63] data_in,
  input  logic        status,
  input  logic        lock,
  input  logic [2:0]  rd_sel,
  output logic [15:0] rd_count,
  output logic [15:0] total_votes,
  output logic        vote_ok,
  output logic        vote_err,
  output logic [2:0]  err_code,
  output logic        overrun
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  localparam logic [7:0] LP_NCAND8 = 8'(NUM_CAND);
  localparam logic [3:0] LP_NCAND4 = 4'(NUM_CAND);

  logic [1:0]  r_state;
  logic        r_status_q;
  logic [0:63] r_pkt;
  logic [15:0] r_cnt [0:7];
  logic [15:0] r_total;
  logic [31:0] r_last_seq;
  logic [2:0]  r_err_code;
  logic        r_vote_ok;
  logic        r_vote_err;
  logic        r_overrun;

  logic        w_pkt_evt;
  logic [7:0]  w_sync;
  logic [7:0]  w_booth;
  logic [7:0]  w_cand;
  logic [31:0] w_seq;
  logic [7:0]  w_csum_rx;
  logic [7:0]  w_csum_calc;
  logic [2:0]  w_err;

  assign w_pkt_evt   = status & ~r_status_q;
  assign w_sync      = r_pkt[0:7];
  assign w_booth     = r_pkt[8:15];
  assign w_cand      = r_pkt[16:23];
  assign w_seq       = r_pkt[24:55];
  assign w_csum_rx   = r_pkt[56:63];
  assign w_csum_calc = r_pkt[0:7] ^ r_pkt[8:15] ^ r_pkt[16:23] ^ r_pkt[24:31]
                     ^ r_pkt[32:39] ^ r_pkt[40:47] ^ r_pkt[48:55];

  // First failing check wins; the saturation check is only reached once the candidate index is known valid.
  always_comb begin
    w_err = 3'd0;
    if (lock)                                     w_err = 3'd6;
    else if (w_sync != 8'hA5)                     w_err = 3'd1;
    else if (w_csum_rx != w_csum_calc)            w_err = 3'd2;
    else if (w_booth != BOOTH_ID)                 w_err = 3'd3;
    else if (w_cand >= LP_NCAND8)                 w_err = 3'd4;
    else if (w_seq <= r_last_seq)                 w_err = 3'd5;
    else if (r_cnt[w_cand[2:0]] == 16'hFFFF || r_total == 16'hFFFF)
                                                  w_err = 3'd7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_status_q <= 1'b0;
      r_pkt      <= '0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= 16'h0000;
      r_total    <= 16'h0000;
      r_last_seq <= 32'h0;
      r_err_code <= 3'd0;
      r_vote_ok  <= 1'b0;
      r_vote_err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_status_q <= status;
      r_vote_ok  <= 1'b0;
      r_vote_err <= 1'b0;
      if (w_pkt_evt && r_state != ST_IDLE) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_pkt_evt) begin
            r_pkt   <= data_in;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_state    <= ST_RESULT;
          r_err_code <= w_err;
          if (w_err == 3'd0) begin
            r_cnt[w_cand[2:0]] <= r_cnt[w_cand[2:0]] + 16'd1;
            r_total            <= r_total + 16'd1;
            r_last_seq         <= w_seq;
            r_vote_ok          <= 1'b1;
          end else begin
            r_vote_err <= 1'b1;
          end
        end
        ST_RESULT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_count    = ({1'b0, rd_sel} < LP_NCAND4) ? r_cnt[rd_sel] : 16'h0000;
  assign total_votes = r_total;
  assign vote_ok     = r_vote_ok;
  assign vote_err    = r_vote_err;
  assign err_code    = r_err_code;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_vote_tally.sv
// tb/tb_vote_tally.sv - directed self-checking bench for vote_tally (built with NUM_CAND=6)
module tb_vote_tally;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:63] data_in;
  logic        status;
  logic        lock;
  logic [2:0]  rd_sel;
  logic [15:0] rd_count;
  logic [15:0] total_votes;
  logic        vote_ok;
  logic        vote_err;
  logic [2:0]  err_code;
  logic        overrun;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vote_tally #(.BOOTH_ID(8'h01), .NUM_CAND(6)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .status(status), .lock(lock),
    .rd_sel(rd_sel), .rd_count(rd_count), .total_votes(total_votes),
    .vote_ok(vote_ok), .vote_err(vote_err), .err_code(err_code), .overrun(overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Event cycle T, then returns sampled pulses at T+1 (early), T+2 (ok/err) and T+3 (late).
  task automatic send_pkt(input logic [63:0] pkt, output logic early, output logic ok,
                          output logic err, output logic late);
    step();
    data_in = pkt;
    status  = 1'b1;
    step();
    status = 1'b0;
    early  = vote_ok | vote_err;
    step();
    ok  = vote_ok;
    err = vote_err;
    step();
    late = vote_ok | vote_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; status = 1'b0; lock = 1'b0; data_in = '0; rd_sel = 3'd3;
    step(); step();
    rst = 1'b0;
    step();
    n_total++; if (total_votes !== 16'd0) $display("FAIL reset_total: got %0d expected 0", total_votes); else n_pass++;
    n_total++; if (rd_count !== 16'd0) $display("FAIL reset_rd_count: got %0d expected 0", rd_count); else n_pass++;
    n_total++; if ({vote_ok, vote_err, overrun} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {vote_ok, vote_err, overrun}); else n_pass++;
    n_total++; if (err_code !== 3'd0) $display("FAIL reset_err_code: got %0d expected 0", err_code); else n_pass++;
  endtask

  task automatic test_accept();
    logic e, o, r, l;
    send_pkt(64'hA5010300000001A6, e, o, r, l);
    n_total++; if ({e, o, r, l} !== 4'b0100) $display("FAIL accept_timing: got early/ok/err/late=%b expected 0100", {e, o, r, l}); else n_pass++;
    rd_sel = 3'd3; #1;
    n_total++; if (rd_count !== 16'd1) $display("FAIL accept_rd3: got %0d expected 1", rd_count); else n_pass++;
    n_total++; if (total_votes !== 16'd1) $display("FAIL accept_total: got %0d expected 1", total_votes); else n_pass++;
    n_total++; if (err_code !== 3'd0) $display("FAIL accept_code: got %0d expected 0", err_code); else n_pass++;
  endtask

  task automatic test_replay();
    logic e, o, r, l;
    send_pkt(64'hA5010300000001A6, e, o, r, l);
    n_total++; if ({e, o, r, l} !== 4'b0010) $display("FAIL replay_timing: got early/ok/err/late=%b expected 0010", {e, o, r, l}); else n_pass++;
    n_total++; if (err_code !== 3'd5) $display("FAIL replay_code: got %0d expected 5", err_code); else n_pass++;
    n_total++; if (rd_count !== 16'd1 || total_votes !== 16'd1) $display("FAIL replay_counts: got rd=%0d total=%0d expected 1/1", rd_count, total_votes); else n_pass++;
    send_pkt(64'hA5010300000002A5, e, o, r, l);
    n_total++; if ({o, r} !== 2'b10) $display("FAIL seq2_pulse: got ok/err=%b expected 10", {o, r}); else n_pass++;
    n_total++; if (rd_count !== 16'd2 || total_votes !== 16'd2) $display("FAIL seq2_counts: got rd=%0d total=%0d expected 2/2", rd_count, total_votes); else n_pass++;
  endtask

  task automatic test_field_errors();
    logic [63:0] pkts  [5] = '{64'hA501030000000400, 64'hA5010900000004A9, 64'hA5020300000004A0,
                               64'h5A0103000000045C, 64'hA5010600000004A6};
    logic [2:0]  codes [5] = '{3'd2, 3'd4, 3'd3, 3'd1, 3'd4};
    logic e, o, r, l;
    for (int i = 0; i < 5; i++) begin
      send_pkt(pkts[i], e, o, r, l);
      n_total++; if ({o, r} !== 2'b01 || err_code !== codes[i]) $display("FAIL field_err[%0d]: got ok/err=%b code=%0d expected 01 code=%0d", i, {o, r}, err_code, codes[i]); else n_pass++;
    end
    n_total++; if (total_votes !== 16'd2) $display("FAIL field_total: got %0d expected 2", total_votes); else n_pass++;
  endtask

  task automatic test_lock();
    logic e, o, r, l;
    lock = 1'b1;
    send_pkt(64'hA5010300000003A4, e, o, r, l);
    n_total++; if ({o, r} !== 2'b01 || err_code !== 3'd6) $display("FAIL lock_reject: got ok/err=%b code=%0d expected 01 code=6", {o, r}, err_code); else n_pass++;
    lock = 1'b0;
    send_pkt(64'hA5010300000003A4, e, o, r, l);
    rd_sel = 3'd3; #1;
    n_total++; if ({o, r} !== 2'b10 || err_code !== 3'd0) $display("FAIL unlock_accept: got ok/err=%b code=%0d expected 10 code=0", {o, r}, err_code); else n_pass++;
    n_total++; if (rd_count !== 16'd3 || total_votes !== 16'd3) $display("FAIL unlock_counts: got rd=%0d total=%0d expected 3/3", rd_count, total_votes); else n_pass++;
  endtask

  task automatic test_rd_range();
    logic e, o, r, l;
    send_pkt(64'hA5010500000004A5, e, o, r, l);
    rd_sel = 3'd5; #1;
    n_total++; if (o !== 1'b1 || rd_count !== 16'd1) $display("FAIL cand5: got ok=%b rd=%0d expected 1/1", o, rd_count); else n_pass++;
    rd_sel = 3'd6; #1;
    n_total++; if (rd_count !== 16'd0) $display("FAIL rd_sel6: got %0d expected 0", rd_count); else n_pass++;
    rd_sel = 3'd7; #1;
    n_total++; if (rd_count !== 16'd0) $display("FAIL rd_sel7: got %0d expected 0", rd_count); else n_pass++;
  endtask

  task automatic test_hold_high();
    int oks = 0;
    step();
    data_in = 64'hA5010000000005A1;
    status  = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (vote_ok) oks++; end
    status = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); if (vote_ok) oks++; end
    n_total++; if (oks !== 1) $display("FAIL hold_high_pulses: got %0d expected 1", oks); else n_pass++;
    n_total++; if (total_votes !== 16'd5 || overrun !== 1'b0) $display("FAIL hold_high_state: got total=%0d overrun=%b expected 5/0", total_votes, overrun); else n_pass++;
  endtask

  task automatic test_overrun();
    int oks = 0;
    step(); data_in = 64'hA5010100000006A3; status = 1'b1;
    step(); status = 1'b0; if (vote_ok) oks++;
    step(); data_in = 64'hA5010100000007A2; status = 1'b1; if (vote_ok) oks++;
    step(); status = 1'b0; if (vote_ok) oks++;
    for (int i = 0; i < 6; i++) begin step(); if (vote_ok) oks++; end
    rd_sel = 3'd1; #1;
    n_total++; if (oks !== 1) $display("FAIL overrun_pulses: got %0d expected 1", oks); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL overrun_flag: got %b expected 1", overrun); else n_pass++;
    n_total++; if (rd_count !== 16'd1 || total_votes !== 16'd6) $display("FAIL overrun_counts: got rd=%0d total=%0d expected 1/6", rd_count, total_votes); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    step(); data_in = 64'hA5010200000008AE; status = 1'b1;
    step(); status = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; if (vote_ok | vote_err) pulses++;
    for (int i = 0; i < 4; i++) begin step(); if (vote_ok | vote_err) pulses++; end
    rd_sel = 3'd2; #1;
    n_total++; if (pulses !== 0) $display("FAIL reset_mid_pulses: got %0d expected 0", pulses); else n_pass++;
    n_total++; if (total_votes !== 16'd0 || rd_count !== 16'd0) $display("FAIL reset_mid_counts: got total=%0d rd=%0d expected 0/0", total_votes, rd_count); else n_pass++;
    rd_sel = 3'd3; #1;
    n_total++; if (rd_count !== 16'd0 || overrun !== 1'b0) $display("FAIL reset_mid_clear: got rd3=%0d overrun=%b expected 0/0", rd_count, overrun); else n_pass++;
  endtask

  task automatic test_seq_zero();
    logic e, o, r, l;
    send_pkt(64'hA5010300000000A7, e, o, r, l);
    n_total++; if ({o, r} !== 2'b01 || err_code !== 3'd5) $display("FAIL seq_zero: got ok/err=%b code=%0d expected 01 code=5", {o, r}, err_code); else n_pass++;
    send_pkt(64'hA5010300000001A6, e, o, r, l);
    n_total++; if (o !== 1'b1 || total_votes !== 16'd1) $display("FAIL seq_one_after_reset: got ok=%b total=%0d expected 1/1", o, total_votes); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_accept();
    test_replay();
    test_field_errors();
    test_lock();
    test_rd_range();
    test_hold_high();
    test_overrun();
    test_reset_mid();
    test_seq_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
